// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits byte/half/word loads and stores into
// sequential single-byte memory accesses and stalls the pipeline meanwhile.
module mem_byte_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        misalign_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_idx;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_mis;

    logic        w_misalign;
    logic [1:0]  w_last_idx;
    logic        w_last;
    logic        w_access;
    logic [7:0]  w_wbyte;
    logic [31:0] w_asm_next;
    logic [31:0] w_load_res;
    logic        w_unused_rdata;

    // Upper read-data bits are not part of the byte-wide memory path.
    assign w_unused_rdata = ^mem_rdata_i[31:8];

    assign w_misalign = (size_i == 2'b11)
                     || (size_i == 2'b01 && addr_i[0])
                     || (size_i == 2'b10 && addr_i[1:0] != 2'b00);

    assign w_last_idx = (r_size == 2'b10) ? 2'd3 :
                        (r_size == 2'b01) ? 2'd1 : 2'd0;
    assign w_last     = (r_idx == w_last_idx);

    // Reset masks the memory strobes so an aborted transfer writes nothing more.
    assign w_access    = (r_state == S_ACCESS) && !rst_i;
    assign w_wbyte     = r_wdata[{r_idx, 3'b000} +: 8];
    assign mem_addr_o  = w_access ? (r_addr + {30'd0, r_idx}) : 32'd0;
    assign mem_read_o  = w_access && !r_we;
    assign mem_write_o = w_access && r_we;
    assign mem_wdata_o = (w_access && r_we) ? {24'd0, w_wbyte} : 32'd0;

    assign busy_o = !rst_i
                 && ((r_state == S_IDLE && req_i) || r_state == S_ACCESS);

    assign done_o     = r_done;
    assign misalign_o = r_mis;
    assign rdata_o    = r_rdata;

    // Assembly register with this cycle's read byte merged in.
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_idx, 3'b000} +: 8] = mem_rdata_i[7:0];
    end

    // Sign- or zero-extend the assembled bytes to 32 bits.
    always_comb begin
        w_load_res = w_asm_next;
        if (r_size == 2'b00) begin
            w_load_res = {{24{r_sign & w_asm_next[7]}}, w_asm_next[7:0]};
        end else if (r_size == 2'b01) begin
            w_load_res = {{16{r_sign & w_asm_next[15]}}, w_asm_next[15:0]};
        end
    end

    // Transfer FSM with request latch, byte index and registered status.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_sign  <= 1'b0;
            r_idx   <= 2'd0;
            r_asm   <= 32'd0;
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_mis  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_we    <= we_i;
                        r_size  <= size_i;
                        r_sign  <= sign_i;
                        r_idx   <= 2'd0;
                        r_asm   <= 32'd0;
                        if (w_misalign) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_mis   <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_asm <= w_asm_next;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= w_load_res;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
